// File: rtl/ppu_obj_pkg.sv
// rtl/ppu_obj_pkg.sv - shared types and constants for the OAM object line scanner
//
// Contents:
//   slot_t        per-line object slot record (valid, fetched, OAM index, X, unflipped row)
//   eval_state_e  OAM evaluation FSM states
//   fetch_state_e per-object tile/attribute fetch FSM states
//   OAM_OFS_*     byte offsets of the four bytes of an OAM entry
package ppu_obj_pkg;

  typedef struct packed {
    logic       valid;
    logic       fetched;
    logic [5:0] no;
    logic [7:0] x;
    logic [3:0] row0;
  } slot_t;

  typedef enum logic [1:0] {
    E_IDLE,
    E_Y,
    E_X,
    E_DONE
  } eval_state_e;

  typedef enum logic [2:0] {
    F_IDLE,
    F_TILE,
    F_ATTR,
    F_LOAD,
    F_REQ
  } fetch_state_e;

  localparam logic [1:0] OAM_OFS_Y    = 2'd0;
  localparam logic [1:0] OAM_OFS_X    = 2'd1;
  localparam logic [1:0] OAM_OFS_TILE = 2'd2;
  localparam logic [1:0] OAM_OFS_ATTR = 2'd3;

endpackage

// File: rtl/obj_line_scanner_if.sv
// rtl/obj_line_scanner_if.sv - OAM read port and fetcher handshake bundle
//
// Signals:
//   oam_addr  scanner -> OAM   read address
//   oam_q     OAM -> scanner   read data, one ce cycle after the address
//   obj_req   scanner -> fetch tile/attr/row valid for obj_slot
//   obj_ack   fetch -> scanner object consumed
//   obj_slot  scanner -> fetch slot index being served
//   obj_tile  scanner -> fetch OAM byte 2
//   obj_attr  scanner -> fetch OAM byte 3
//   obj_row   scanner -> fetch flipped row within the object
// Modports: master = scanner side, slave = OAM/fetcher side.
interface obj_line_scanner_if #(
  parameter int SLOT_W = 4
);
  logic [7:0]        oam_addr;
  logic [7:0]        oam_q;
  logic              obj_req;
  logic              obj_ack;
  logic [SLOT_W-1:0] obj_slot;
  logic [7:0]        obj_tile;
  logic [7:0]        obj_attr;
  logic [3:0]        obj_row;

  modport master (
    output oam_addr, obj_req, obj_slot, obj_tile, obj_attr, obj_row,
    input  oam_q, obj_ack
  );

  modport slave (
    input  oam_addr, obj_req, obj_slot, obj_tile, obj_attr, obj_row,
    output oam_q, obj_ack
  );
endinterface

// File: rtl/obj_slot_match.sv
// rtl/obj_slot_match.sv - combinational slot/X matcher with lowest-index priority
//
// Ports:
//   i_valid    per-slot valid flags
//   i_fetched  per-slot fetched flags
//   i_x        per-slot object X
//   i_h_cnt    current pixel X
//   o_match    per-slot match (valid, not yet fetched, X equal)
//   o_sel      lowest matching slot index
//   o_any      at least one slot matches
module obj_slot_match #(
  parameter int SLOTS  = 10,
  parameter int SLOT_W = 4
) (
  input  logic [SLOTS-1:0]      i_valid,
  input  logic [SLOTS-1:0]      i_fetched,
  input  logic [SLOTS-1:0][7:0] i_x,
  input  logic [7:0]            i_h_cnt,
  output logic [SLOTS-1:0]      o_match,
  output logic [SLOT_W-1:0]     o_sel,
  output logic                  o_any
);

  always_comb begin
    o_match = '0;
    for (int i = 0; i < SLOTS; i++) begin
      o_match[i] = i_valid[i] && !i_fetched[i] && (i_x[i] == i_h_cnt);
    end
  end

  // Walk downwards so the last assignment, i.e. the lowest index, wins.
  always_comb begin
    o_sel = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (o_match[i]) o_sel = SLOT_W'(i);
    end
  end

  assign o_any = |o_match;

endmodule

// File: rtl/obj_line_scanner.sv
// rtl/obj_line_scanner.sv - per-line OAM scan and in-X-order object fetch engine
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   ce                clock enable for all state
//   lcd_on            0 holds the block cleared
//   size16            object height 16 when 1, else 8
//   obj_en            enables fetch requests
//   line_start        abort, clear slots, start evaluation
//   v_cnt, h_cnt      current line / pixel X
//   eval_busy         evaluation running
//   eval_done         evaluation finished (held until line_start)
//   overflow          an on-line object was dropped for lack of slots
//   hit_count         on-line objects found, saturating at 127
//   bus               OAM read port and fetcher handshake (master side)
module obj_line_scanner
  import ppu_obj_pkg::*;
#(
  parameter int OBJ_COUNT = 40,
  parameter int SLOTS     = 10,
  parameter int SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               lcd_on,
  input  logic               size16,
  input  logic               obj_en,
  input  logic               line_start,
  input  logic [7:0]         v_cnt,
  input  logic [7:0]         h_cnt,
  output logic               eval_busy,
  output logic               eval_done,
  output logic               overflow,
  output logic [6:0]         hit_count,
  obj_line_scanner_if.master bus
);

  eval_state_e          r_estate, w_estate_nxt;
  fetch_state_e         r_fstate, w_fstate_nxt;
  logic [6:0]           r_idx;
  logic [7:0]           r_y;
  logic [4:0]           r_count;
  logic                 r_overflow;
  logic [6:0]           r_hits;
  slot_t [SLOTS-1:0]    r_slots;
  logic [SLOT_W-1:0]    r_fslot;
  logic [5:0]           r_fno;
  logic [3:0]           r_frow0;
  logic [7:0]           r_tile;
  logic [7:0]           r_attr;

  logic                 w_abort;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_commit;
  logic                 w_online;
  logic [8:0]           w_line;
  logic [8:0]           w_ybot;
  logic [3:0]           w_row0;
  logic [5:0]           w_commit_no;
  logic [SLOTS-1:0]     w_valid;
  logic [SLOTS-1:0]     w_fetched;
  logic [SLOTS-1:0][7:0] w_x;
  logic [SLOTS-1:0]     w_match;
  logic [SLOT_W-1:0]    w_sel;
  logic                 w_any;
  slot_t                w_sel_slot;
  logic [3:0]           w_flip;

  assign w_abort  = !lcd_on || line_start;
  assign w_busy   = (r_estate == E_Y) || (r_estate == E_X);
  assign w_done   = (r_estate == E_DONE);
  // E_Y with idx>0 sees X of entry idx-1 on oam_q and commits that entry.
  assign w_commit = (r_estate == E_Y) && (r_idx != 7'd0);

  // On-line test done at 9 bits so Y near 255 never wraps into range.
  assign w_line   = {1'b0, v_cnt} + 9'd16;
  assign w_ybot   = {1'b0, r_y} + (size16 ? 9'd16 : 9'd8);
  assign w_online = (w_line >= {1'b0, r_y}) && (w_line < w_ybot);
  // The +16 bias vanishes modulo 16, so the low nibble is just v - Y.
  assign w_row0      = v_cnt[3:0] - r_y[3:0];
  assign w_commit_no = r_idx[5:0] - 6'd1;

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      w_valid[i]   = r_slots[i].valid;
      w_fetched[i] = r_slots[i].fetched;
      w_x[i]       = r_slots[i].x;
    end
  end

  obj_slot_match #(
    .SLOTS  (SLOTS),
    .SLOT_W (SLOT_W)
  ) u_match (
    .i_valid   (w_valid),
    .i_fetched (w_fetched),
    .i_x       (w_x),
    .i_h_cnt   (h_cnt),
    .o_match   (w_match),
    .o_sel     (w_sel),
    .o_any     (w_any)
  );

  always_comb begin
    w_sel_slot = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (w_sel == SLOT_W'(i)) w_sel_slot = r_slots[i];
    end
  end

  always_comb begin
    w_estate_nxt = r_estate;
    case (r_estate)
      E_Y:     w_estate_nxt = (r_idx == 7'(OBJ_COUNT)) ? E_DONE : E_X;
      E_X:     w_estate_nxt = E_Y;
      default: w_estate_nxt = r_estate;
    endcase
    if (!lcd_on)         w_estate_nxt = E_IDLE;
    else if (line_start) w_estate_nxt = E_Y;
  end

  always_comb begin
    w_fstate_nxt = r_fstate;
    case (r_fstate)
      F_IDLE:  if (w_done && obj_en && w_any) w_fstate_nxt = F_TILE;
      F_TILE:  w_fstate_nxt = F_ATTR;
      F_ATTR:  w_fstate_nxt = F_LOAD;
      F_LOAD:  w_fstate_nxt = F_REQ;
      F_REQ:   if (bus.obj_ack) w_fstate_nxt = F_IDLE;
      default: w_fstate_nxt = F_IDLE;
    endcase
    if (w_abort) w_fstate_nxt = F_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estate   <= E_IDLE;
      r_fstate   <= F_IDLE;
      r_idx      <= '0;
      r_y        <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_hits     <= '0;
      r_slots    <= '0;
      r_fslot    <= '0;
      r_fno      <= '0;
      r_frow0    <= '0;
      r_tile     <= '0;
      r_attr     <= '0;
    end else if (ce) begin
      r_estate <= w_estate_nxt;
      r_fstate <= w_fstate_nxt;
      if (w_abort) begin
        r_idx      <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
        r_hits     <= '0;
        r_slots    <= '0;
      end else begin
        if (r_estate == E_X) begin
          r_y   <= bus.oam_q;
          r_idx <= r_idx + 7'd1;
        end
        if (w_commit && w_online) begin
          if (r_hits != 7'h7F) r_hits <= r_hits + 7'd1;
          if (r_count < 5'(SLOTS)) r_count <= r_count + 5'd1;
          else                     r_overflow <= 1'b1;
        end
        for (int i = 0; i < SLOTS; i++) begin
          if (w_commit && w_online && (r_count == 5'(i))) begin
            r_slots[i] <= '{valid: 1'b1, fetched: 1'b0, no: w_commit_no,
                            x: bus.oam_q, row0: w_row0};
          end
          if ((r_fstate == F_REQ) && bus.obj_ack && (r_fslot == SLOT_W'(i))) begin
            r_slots[i].fetched <= 1'b1;
          end
        end
        // Capture the served object once so an h_cnt change mid-fetch is harmless.
        if ((r_fstate == F_IDLE) && (w_fstate_nxt == F_TILE)) begin
          r_fslot <= w_sel;
          r_fno   <= w_sel_slot.no;
          r_frow0 <= w_sel_slot.row0;
        end
        if (r_fstate == F_ATTR) r_tile <= bus.oam_q;
        if (r_fstate == F_LOAD) r_attr <= bus.oam_q;
      end
    end
  end

  always_comb begin
    bus.oam_addr = 8'h00;
    if (w_busy)                  bus.oam_addr = {r_idx[5:0], (r_estate == E_X) ? OAM_OFS_X : OAM_OFS_Y};
    else if (r_fstate == F_TILE) bus.oam_addr = {r_fno, OAM_OFS_TILE};
    else if (r_fstate == F_ATTR) bus.oam_addr = {r_fno, OAM_OFS_ATTR};
  end

  // Y-flip mirrors within the object height; 8-high rows never exceed 7.
  assign w_flip       = size16 ? 4'hF : 4'h7;
  assign bus.obj_row  = r_attr[6] ? (r_frow0 ^ w_flip) : r_frow0;
  assign bus.obj_req  = (r_fstate == F_REQ);
  assign bus.obj_slot = r_fslot;
  assign bus.obj_tile = r_tile;
  assign bus.obj_attr = r_attr;

  assign eval_busy = w_busy;
  assign eval_done = w_done;
  assign overflow  = r_overflow;
  assign hit_count = r_hits;

endmodule

// File: tb/tb_obj_line_scanner.sv
// tb/tb_obj_line_scanner.sv - scoreboard bench for obj_line_scanner
module tb_obj_line_scanner;

  typedef struct packed {
    logic [3:0] slot;
    logic [7:0] tile;
    logic [7:0] attr;
    logic [3:0] row;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b1;
  logic       lcd_on = 1'b1;
  logic       size16 = 1'b0;
  logic       obj_en = 1'b0;
  logic       line_start = 1'b0;
  logic [7:0] v_cnt = 8'd0;
  logic [7:0] h_cnt = 8'd0;
  logic       eval_busy, eval_done, overflow;
  logic [6:0] hit_count;

  logic       auto_ack = 1'b0;
  logic       man_ack = 1'b0;
  int         ack_delay = 2;
  int         req_age = 0;
  logic       mon_prev = 1'b0;
  int         n_req = 0;
  int         total = 0;
  int         bad = 0;
  exp_t       q[$];
  logic [7:0] oam [256];

  obj_line_scanner_if #(.SLOT_W(4)) bus ();

  obj_line_scanner #(.OBJ_COUNT(40), .SLOTS(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .lcd_on     (lcd_on),
    .size16     (size16),
    .obj_en     (obj_en),
    .line_start (line_start),
    .v_cnt      (v_cnt),
    .h_cnt      (h_cnt),
    .eval_busy  (eval_busy),
    .eval_done  (eval_done),
    .overflow   (overflow),
    .hit_count  (hit_count),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ce) bus.oam_q <= oam[bus.oam_addr];

  assign bus.obj_ack = auto_ack | man_ack;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.obj_req && ack_delay >= 0) begin
        auto_ack = (req_age == ack_delay);
        req_age++;
      end else begin
        auto_ack = 1'b0;
        req_age = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (bus.obj_req && !mon_prev) begin
        exp_t got;
        exp_t e;
        n_req++;
        total++;
        got = '{slot: bus.obj_slot, tile: bus.obj_tile, attr: bus.obj_attr, row: bus.obj_row};
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_req: slot=%0d tile=%h attr=%h row=%h, none expected",
                   got.slot, got.tile, got.attr, got.row);
        end else begin
          e = q.pop_front();
          if (got !== e) begin
            bad++;
            $display("FAIL obj_req: got slot=%0d tile=%h attr=%h row=%h, expected slot=%0d tile=%h attr=%h row=%h",
                     got.slot, got.tile, got.attr, got.row, e.slot, e.tile, e.attr, e.row);
          end
        end
      end
      mon_prev = bus.obj_req;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input int slot, input int tile, input int attr, input int row);
    q.push_back('{slot: 4'(slot), tile: 8'(tile), attr: 8'(attr), row: 4'(row)});
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 256; i++) oam[i] = 8'h00;
  endtask

  task automatic set_obj(input int idx, input int y, input int x, input int tile, input int attr);
    oam[idx*4+0] = 8'(y);
    oam[idx*4+1] = 8'(x);
    oam[idx*4+2] = 8'(tile);
    oam[idx*4+3] = 8'(attr);
  endtask

  task automatic load_twelve();
    clear_oam();
    for (int i = 0; i < 12; i++) set_obj(i, 20, 8 + i, 8'h80 + i, 0);
  endtask

  task automatic load_pair();
    clear_oam();
    set_obj(2, 20, 30, 8'h22, 8'h00);
    set_obj(7, 20, 30, 8'h77, 8'h40);
  endtask

  // Pulses line_start and checks busy/done timing against 2*OBJ_COUNT+2.
  task automatic start_line(input string name);
    int cnt;
    line_start = 1'b1;
    step(1);
    line_start = 1'b0;
    check({name, "_busy_rise"}, eval_busy, 1);
    cnt = 1;
    while (!eval_done && cnt < 200) begin
      step(1);
      cnt++;
    end
    check({name, "_done_cycle"}, cnt, 82);
    check({name, "_busy_fall"}, eval_busy, 0);
  endtask

  task automatic serve_wait(input int bound, input string name);
    int cnt = 0;
    while ((q.size() != 0 || bus.obj_req) && cnt < bound) begin
      step(1);
      cnt++;
    end
    check({name, "_served"}, (q.size() == 0 && !bus.obj_req), 1);
  endtask

  task automatic wait_req(input int bound, input string name);
    int cnt = 0;
    while (!bus.obj_req && cnt < bound) begin
      step(1);
      cnt++;
    end
    check({name, "_req_seen"}, bus.obj_req, 1);
  endtask

  initial begin
    int base;
    clear_oam();
    step(2);
    check("rst_busy", eval_busy, 0);
    check("rst_done", eval_done, 0);
    check("rst_ovf", overflow, 0);
    check("rst_hits", hit_count, 0);
    check("rst_req", bus.obj_req, 0);
    check("rst_addr", bus.oam_addr, 0);
    reset = 1'b0;
    step(1);

    // Twelve on-line objects, ten slots: slots hold 0..9, two dropped.
    load_twelve();
    v_cnt = 8'd4;
    obj_en = 1'b1;
    ack_delay = 2;
    start_line("t1");
    check("t1_overflow", overflow, 1);
    check("t1_hits", hit_count, 12);
    for (int i = 0; i < 10; i++) begin
      push_exp(i, 8'h80 + i, 0, 0);
      h_cnt = 8'(8 + i);
      serve_wait(40, "t1_sweep");
    end
    base = n_req;
    for (int i = 10; i < 12; i++) begin
      h_cnt = 8'(8 + i);
      step(12);
    end
    check("t1_dropped_no_req", n_req - base, 0);

    // Y-flip row in 16- and 8-high modes.
    clear_oam();
    set_obj(5, 16, 50, 8'h55, 8'h40);
    size16 = 1'b1;
    v_cnt = 8'd3;
    h_cnt = 8'd50;
    push_exp(0, 8'h55, 8'h40, 4'hC);
    start_line("t2a");
    check("t2_hits", hit_count, 1);
    check("t2_overflow", overflow, 0);
    serve_wait(40, "t2a");
    size16 = 1'b0;
    push_exp(0, 8'h55, 8'h40, 4'h4);
    start_line("t2b");
    serve_wait(40, "t2b");

    // Two objects at the same X served in slot order, then nothing more.
    load_pair();
    v_cnt = 8'd4;
    h_cnt = 8'd30;
    push_exp(0, 8'h22, 8'h00, 0);
    push_exp(1, 8'h77, 8'h40, 7);
    base = n_req;
    start_line("t3");
    check("t3_hits", hit_count, 2);
    serve_wait(60, "t3");
    step(20);
    check("t3_two_reqs_only", n_req - base, 2);

    // obj_en gating, three fetch cycles before obj_req, same-cycle ack.
    obj_en = 1'b0;
    ack_delay = 0;
    base = n_req;
    start_line("t4");
    step(10);
    check("t4_no_req_disabled", n_req - base, 0);
    push_exp(0, 8'h22, 8'h00, 0);
    push_exp(1, 8'h77, 8'h40, 7);
    obj_en = 1'b1;
    step(3);
    check("t4_req_not_yet", bus.obj_req, 0);
    step(1);
    check("t4_req_latency", bus.obj_req, 1);
    step(1);
    check("t4_same_cycle_ack", bus.obj_req, 0);
    serve_wait(40, "t4");

    // line_start (with a simultaneous ack) while obj_req is high.
    ack_delay = -1;
    push_exp(0, 8'h22, 8'h00, 0);
    push_exp(1, 8'h77, 8'h40, 7);
    start_line("t5a");
    wait_req(20, "t5_first");
    man_ack = 1'b1;
    step(1);
    man_ack = 1'b0;
    wait_req(20, "t5_second");
    line_start = 1'b1;
    man_ack = 1'b1;
    step(1);
    line_start = 1'b0;
    man_ack = 1'b0;
    check("t5_req_drop", bus.obj_req, 0);
    check("t5_busy", eval_busy, 1);
    push_exp(0, 8'h22, 8'h00, 0);
    push_exp(1, 8'h77, 8'h40, 7);
    ack_delay = 2;
    serve_wait(200, "t5_refetch");

    // Asynchronous reset mid-evaluation with ce low.
    obj_en = 1'b0;
    load_twelve();
    line_start = 1'b1;
    step(1);
    line_start = 1'b0;
    step(19);
    check("t6_pre_hits", hit_count, 9);
    check("t6_pre_addr", bus.oam_addr, 37);
    ce = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_rst_busy", eval_busy, 0);
    check("t6_rst_hits", hit_count, 0);
    check("t6_rst_addr", bus.oam_addr, 0);
    check("t6_rst_req", bus.obj_req, 0);
    step(2);
    reset = 1'b0;
    ce = 1'b1;
    step(1);

    // lcd_on low holds the block cleared even across line_start.
    lcd_on = 1'b0;
    line_start = 1'b1;
    step(1);
    line_start = 1'b0;
    step(100);
    check("t7_lcd_off_done", eval_done, 0);
    check("t7_lcd_off_busy", eval_busy, 0);
    lcd_on = 1'b1;
    start_line("t7");
    check("t7_hits", hit_count, 12);
    check("t7_overflow", overflow, 1);

    step(5);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
